// File: rtl/shader_exec_unit_if.sv
// shader_exec_unit_if: instruction and result channels of the shader execution stage
interface shader_exec_unit_if #(
    parameter int OPCODE_W = 4,
    parameter int LANES    = 4,
    parameter int LANE_W   = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [OPCODE_W-1:0]     in_opcode;
    logic                    in_is_vector;
    logic [LANES*LANE_W-1:0] in_src_a;
    logic [LANES*LANE_W-1:0] in_src_b;
    logic                    acc_clear;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*LANE_W-1:0] out_result;
    logic [OPCODE_W-1:0]     out_opcode;
    logic                    out_err;

    modport master (
        output in_valid, in_opcode, in_is_vector, in_src_a, in_src_b, acc_clear, out_ready,
        input  in_ready, out_valid, out_result, out_opcode, out_err
    );

    modport slave (
        input  in_valid, in_opcode, in_is_vector, in_src_a, in_src_b, acc_clear, out_ready,
        output in_ready, out_valid, out_result, out_opcode, out_err
    );
endinterface

// File: rtl/shader_exec_unit.sv
// shader_exec_unit: one-at-a-time ADD/SUB/MUL/MAC lane executor with per-lane accumulators
module shader_exec_unit #(
    parameter int OPCODE_W = 4,
    parameter int LANES    = 4,
    parameter int LANE_W   = 16,
    parameter int MUL_LAT  = 3
) (
    input logic clk,
    input logic rst_n,
    shader_exec_unit_if.slave bus
);
    localparam int CNT_W = $clog2(MUL_LAT);
    localparam logic [OPCODE_W-1:0] OP_ADD = 0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 1;
    localparam logic [OPCODE_W-1:0] OP_MUL = 2;
    localparam logic [OPCODE_W-1:0] OP_MAC = 3;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt;
    logic [OPCODE_W-1:0]     op_q;
    logic                    vec_q;
    logic [LANES*LANE_W-1:0] a_q, b_q;
    logic [LANES*LANE_W-1:0] acc, acc_next;
    logic [LANES*LANE_W-1:0] res_next;
    logic [LANES*LANE_W-1:0] result;
    logic                    err;
    logic                    accept, fin, commit, illegal, long_op;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign fin     = (state == EXEC) && (cnt == '0);
    assign illegal = op_q > OP_MAC;
    assign commit  = fin && (op_q == OP_MAC);
    assign long_op = (bus.in_opcode == OP_MUL) || (bus.in_opcode == OP_MAC);

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = result;
    assign bus.out_opcode = op_q;
    assign bus.out_err    = err;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] a, b, prod, prior, val;
        logic              en;
        assign a     = a_q[i*LANE_W +: LANE_W];
        assign b     = b_q[i*LANE_W +: LANE_W];
        assign prod  = a * b;
        assign en    = vec_q || (i == 0);
        assign prior = bus.acc_clear ? '0 : acc[i*LANE_W +: LANE_W];
        // Per-lane result select; illegal opcodes yield zero
        always_comb begin
            val = '0;
            val = (op_q == OP_ADD) ? a + b :
                  (op_q == OP_SUB) ? a - b :
                  (op_q == OP_MUL) ? prod :
                  (op_q == OP_MAC) ? prior + prod : '0;
        end
        assign res_next[i*LANE_W +: LANE_W] = en ? val : '0;
        assign acc_next[i*LANE_W +: LANE_W] = (commit && en) ? prior + prod : prior;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: wait for instruction, count down latency, hold result until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bus.in_valid ? EXEC : IDLE;
            EXEC:    state_next = (cnt == '0) ? DONE : EXEC;
            DONE:    state_next = bus.out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, latency counter, result capture and accumulator update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= '0;
            vec_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
            acc    <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.in_opcode;
                vec_q <= bus.in_is_vector;
                a_q   <= bus.in_src_a;
                b_q   <= bus.in_src_b;
                cnt   <= long_op ? CNT_W'(MUL_LAT - 1) : '0;
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (fin) begin
                result <= res_next;
                err    <= illegal;
            end
            acc <= acc_next;
        end
    end
endmodule

// File: tb/tb_shader_exec_unit.sv
// tb_shader_exec_unit: directed vectors with hand-computed results for shader_exec_unit
module tb_shader_exec_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    shader_exec_unit_if bus ();

    shader_exec_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input string tag, input logic [3:0] op, input logic vec,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat,
                         input logic exp_err, input int clr_at);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        check({tag, "_rdy"}, bus.in_ready, 1);
        bus.in_valid     = 1;
        bus.in_opcode    = op;
        bus.in_is_vector = vec;
        bus.in_src_a     = a;
        bus.in_src_b     = b;
        @(negedge clk);
        bus.in_valid = 0;
        lat     = 0;
        busy_ok = 1;
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready) busy_ok = 0;
            bus.acc_clear = (lat == clr_at);
            @(negedge clk);
            lat++;
        end
        bus.acc_clear = 0;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_res"}, bus.out_result, exp_res);
        check({tag, "_op"}, bus.out_opcode, op);
        check({tag, "_err"}, bus.out_err, exp_err);
    endtask

    task automatic finish(input string tag);
        bus.out_ready = 1;
        @(negedge clk);
        check({tag, "_idle"}, bus.in_ready, 1);
        check({tag, "_nov"}, bus.out_valid, 0);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic vec,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int exp_lat, input logic exp_err);
        start(tag, op, vec, a, b, exp_res, exp_lat, exp_err, -1);
        finish(tag);
    endtask

    initial begin
        logic        stable_ok;
        logic [63:0] held;
        bus.in_valid     = 1;
        bus.in_opcode    = 4'd2;
        bus.in_is_vector = 1;
        bus.in_src_a     = 64'h5;
        bus.in_src_b     = 64'h5;
        bus.acc_clear    = 0;
        bus.out_ready    = 1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.out_result, 0);
        check("rst_opcode", bus.out_opcode, 0);
        check("rst_err", bus.out_err, 0);
        bus.in_valid = 0;
        rst_n = 1;

        run("add_s", 4'd0, 0, 64'h1111_2222_3333_FFFF, 64'h0001_0001_0001_0002, 64'h0000_0000_0000_0001, 1, 0);
        run("sub_v", 4'd1, 1, 64'h8000_0064_0000_0005, 64'h0001_0064_0001_0003, 64'h7FFF_0000_FFFF_0002, 1, 0);
        run("mul_s1", 4'd2, 0, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_02FD, 3, 0);
        run("mul_s2", 4'd2, 0, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0100, 64'h0, 3, 0);
        run("mul_v", 4'd2, 1, 64'h0004_0003_0002_FFFF, 64'h0004_0003_0002_FFFF, 64'h0010_0009_0004_0001, 3, 0);

        @(negedge clk);
        bus.acc_clear = 1;
        @(negedge clk);
        bus.acc_clear = 0;
        run("mac1", 4'd3, 0, 64'h2, 64'h3, 64'd6, 3, 0);
        run("mac2", 4'd3, 0, 64'h2, 64'h3, 64'd12, 3, 0);
        run("mac3", 4'd3, 0, 64'h2, 64'h3, 64'd18, 3, 0);
        start("mac_clr", 4'd3, 0, 64'h2, 64'h3, 64'd6, 3, 0, 2);
        finish("mac_clr");

        run("illegal", 4'd5, 1, 64'h0007_0007_0007_0007, 64'h0003_0003_0003_0003, 64'h0, 1, 1);
        run("mac_after_ill", 4'd3, 0, 64'h1, 64'h1, 64'd7, 3, 0);

        bus.out_ready = 0;
        start("bp", 4'd0, 1, 64'h0004_0003_0002_0001, 64'h0010_0010_0010_0010, 64'h0014_0013_0012_0011, 1, 0, -1);
        held             = 64'h0014_0013_0012_0011;
        bus.in_valid     = 1;
        bus.in_opcode    = 4'd2;
        bus.in_src_a     = 64'h9;
        bus.in_src_b     = 64'h9;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", bus.out_valid, 1);
            check("bp_result", bus.out_result, held);
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 0;
        finish("bp");
        @(negedge clk);
        check("bp_not_taken", bus.in_ready, 1);

        @(negedge clk);
        bus.in_valid     = 1;
        bus.in_opcode    = 4'd3;
        bus.in_is_vector = 0;
        bus.in_src_a     = 64'h4;
        bus.in_src_b     = 64'h4;
        @(negedge clk);
        bus.in_valid = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("rmid_in_ready", bus.in_ready, 1);
        check("rmid_out_valid", bus.out_valid, 0);
        check("rmid_result", bus.out_result, 0);
        stable_ok = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.out_valid) stable_ok = 0;
        end
        check("rmid_no_result", stable_ok, 1);
        run("mac_after_rst", 4'd3, 0, 64'h1, 64'h1, 64'd1, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
